wishbone_bus_if: RTL and testbench

//  Bridges the OpenMIPS MEM-stage load/store request onto the single-master Wishbone-style data bus.
//  The data bus feeds data_ram and other slaves.

---
 rtl/wishbone_bus_if.sv | 200 ++++++++++++++++++++
 tb/tb_wishbone_bus_if.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_bus_if.sv
// -----------------------------------------------------------------------------
// wishbone_bus_if
//   Bridges the OpenMIPS MEM-stage load/store request onto a single-master
//   Wishbone-style data bus. Each request is registered onto the bus. The
//   pipeline is held through stall_o until the slave acks. Load data is kept
//   in a read buffer until the pipeline moves on. A pipeline flush aborts any
//   access that is still in flight.
//
//   Optional feature: define BUS_TIMEOUT_EN to enable the BUSY watchdog. The
//   watchdog ends a bus cycle after TIMEOUT un-acked BUSY cycles. It then
//   returns zero load data and pulses bus_err_o.
//
// Ports
//   clk, rst       clock (rising edge), asynchronous active-low reset
//   cpu_ce_i       MEM-stage access request
//   cpu_we_i       1 = store, 0 = load
//   cpu_addr_i     byte address
//   cpu_sel_i      byte lanes
//   cpu_data_i     store data
//   cpu_data_o     registered load data (read buffer)
//   stall_i        pipeline frozen by ctrl
//   flush_i        exception flush, abort in-flight access
//   stall_o        stall request to ctrl
//   wb_*_o         bus address / write data / we / sel / stb / cyc
//   wb_data_i      bus read data
//   wb_ack_i       slave acknowledge
//   bus_err_o      one-cycle timeout pulse (tied 0 without BUS_TIMEOUT_EN)
//   dbg_state      current FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// Handshake: a bus transfer is in progress while wb_cyc_o & wb_stb_o are
// high. The slave completes it by raising wb_ack_i for one cycle. The CPU side
// has no ready signal of its own. It simply waits while stall_o is high.
// -----------------------------------------------------------------------------
module wishbone_bus_if #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int SEL_W   = DATA_W / 8,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_ce_i,
   input  logic              cpu_we_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [SEL_W-1:0]  cpu_sel_i,
   input  logic [DATA_W-1:0] cpu_data_i,
   output logic [DATA_W-1:0] cpu_data_o,
   input  logic              stall_i,
   input  logic              flush_i,
   output logic              stall_o,
   output logic [ADDR_W-1:0] wb_addr_o,
   output logic [DATA_W-1:0] wb_data_o,
   output logic              wb_we_o,
   output logic [SEL_W-1:0]  wb_sel_o,
   output logic              wb_stb_o,
   output logic              wb_cyc_o,
   input  logic [DATA_W-1:0] wb_data_i,
   input  logic              wb_ack_i,
   output logic              bus_err_o,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              accept;      // request registered onto the bus this edge
   logic              ack_take;    // slave ack completes the cycle this edge
   logic              abort_busy;  // flush kills the in-flight cycle this edge
   logic              timeout_hit; // watchdog ends the cycle this edge
   logic [DATA_W-1:0] rd_buf;

`ifdef BUS_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   logic [7:0] to_cnt;
   logic       bus_err_q;

   // The counter is cleared on BUSY entry and advances once per BUSY cycle
   // without an ack. The cycle in which it steps onto TIMEOUT is the last one.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         to_cnt <= '0;
      end else if (accept) begin
         to_cnt <= '0;
      end else if (state == BUSY && !wb_ack_i) begin
         to_cnt <= to_cnt + 8'd1;
      end
   end

   // An ack and a flush both take priority over the watchdog.
   assign timeout_hit = (state == BUSY) && !flush_i && !wb_ack_i &&
                        (to_cnt == TIMEOUT_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus_err_q <= 1'b0;
      end else begin
         bus_err_q <= timeout_hit;
      end
   end

   assign bus_err_o = bus_err_q;
`else
   assign timeout_hit = 1'b0;
   assign bus_err_o   = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      accept     = 1'b0;
      ack_take   = 1'b0;
      abort_busy = 1'b0;
      stall_o    = 1'b0;
      case (state)
         IDLE: begin
            // Stall immediately so the MEM stage holds while the request
            // is being registered onto the bus. Acks in IDLE belong to an
            // aborted cycle and are ignored.
            stall_o = cpu_ce_i & ~flush_i;
            if (cpu_ce_i && !flush_i) begin
               accept    = 1'b1;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            stall_o = 1'b1;
            if (flush_i) begin
               abort_busy = 1'b1;
               state_nxt  = IDLE;
            end else if (wb_ack_i) begin
               ack_take  = 1'b1;
               state_nxt = DONE;
            end else if (timeout_hit) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            // Hold here until the pipeline advances. This keeps the same
            // instruction from being issued a second time.
            if (flush_i || !stall_i) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // The comb term must also read 0 while reset is asserted.
      if (!rst) begin
         stall_o = 1'b0;
      end
   end

   // Bus-side registers. The address, data and sel values stay on the bus
   // after a cycle ends. Only cyc, stb and we are cleared.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_addr_o <= '0;
         wb_data_o <= '0;
         wb_we_o   <= 1'b0;
         wb_sel_o  <= '0;
         wb_stb_o  <= 1'b0;
         wb_cyc_o  <= 1'b0;
         rd_buf    <= '0;
      end else begin
         if (accept) begin
            wb_addr_o <= cpu_addr_i;
            wb_data_o <= cpu_data_i;
            wb_we_o   <= cpu_we_i;
            wb_sel_o  <= cpu_sel_i;
            wb_stb_o  <= 1'b1;
            wb_cyc_o  <= 1'b1;
         end else if (ack_take || abort_busy || timeout_hit) begin
            wb_we_o  <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
         end
         if (ack_take && !wb_we_o) begin
            rd_buf <= wb_data_i;
         end else if (timeout_hit) begin
            rd_buf <= '0;
         end
      end
   end

   assign cpu_data_o = rd_buf;
   assign dbg_state  = state;

endmodule

// File: tb/tb_wishbone_bus_if.sv
// -----------------------------------------------------------------------------
// tb_wishbone_bus_if
//   Bench for wishbone_bus_if. It applies a table of directed transactions,
//   then a batch of random ones, then hand-written flush, reset and timeout
//   sequences.
//   Expected values come from a transaction-level model. One request costs one
//   IDLE cycle plus one BUSY cycle per strobe. The strobe count is the number
//   of wait cycles plus 1. Load data is the last read value, or 0 after reset
//   or a timeout.
//   Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_wishbone_bus_if;

   // state codes exposed on dbg_state
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DONE = 2'd2;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_ce_i, cpu_we_i;
   logic [31:0] cpu_addr_i, cpu_data_i, cpu_data_o;
   logic [3:0]  cpu_sel_i;
   logic        stall_i, flush_i, stall_o;
   logic [31:0] wb_addr_o, wb_data_o, wb_data_i;
   logic        wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i, bus_err_o;
   logic [3:0]  wb_sel_o;
   logic [1:0]  dbg_state;

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] model_rd = '0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  sel;
      logic [31:0] wdata;
      int          ack_wait;
      logic [31:0] rdata;
      int          hold;
      int          exp_stall;
      int          exp_stb;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs[5];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   wishbone_bus_if #(.ADDR_W(32), .DATA_W(32), .SEL_W(4), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
      .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
      .stall_i(stall_i), .flush_i(flush_i), .stall_o(stall_o),
      .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_we_o(wb_we_o),
      .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
      .wb_data_i(wb_data_i), .wb_ack_i(wb_ack_i), .bus_err_o(bus_err_o),
      .dbg_state(dbg_state)
   );

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " cyc"},  {31'd0, wb_cyc_o},  32'd0);
      chk({tag, " stb"},  {31'd0, wb_stb_o},  32'd0);
      chk({tag, " we"},   {31'd0, wb_we_o},   32'd0);
      chk({tag, " addr"}, wb_addr_o,          32'd0);
      chk({tag, " wdat"}, wb_data_o,          32'd0);
      chk({tag, " sel"},  {28'd0, wb_sel_o},  32'd0);
      chk({tag, " rdat"}, cpu_data_o,         32'd0);
      chk({tag, " stal"}, {31'd0, stall_o},   32'd0);
      chk({tag, " berr"}, {31'd0, bus_err_o}, 32'd0);
   endtask

   // ---------------- driver ----------------
   // Called on a falling edge with the DUT idle. Issues one access. The slave
   // acks in strobe cycle ack_wait+1. The pipeline stays frozen for `hold`
   // cycles after completion. Returns on a falling edge with the DUT idle.
   task automatic run_txn(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                          input logic [31:0] wdata, input int ack_wait, input logic [31:0] rdata,
                          input int hold, input int exp_stall, input int exp_stb);
      int          n_stall;
      int          n_stb;
      bit          done;
      logic [31:0] exp_data;
      exp_data   = exp_q.pop_front();
      cpu_ce_i   = 1'b1;
      cpu_we_i   = we;
      cpu_addr_i = addr;
      cpu_sel_i  = sel;
      cpu_data_i = wdata;
      stall_i    = (hold > 0);
      #1;
      n_stall = int'(stall_o);
      n_stb   = 0;
      done    = 1'b0;
      @(negedge clk);
      cpu_ce_i   = 1'b0;
      cpu_data_i = $urandom();
      for (int k = 0; k < 40; k++) begin
         if (!wb_stb_o) begin
            done = 1'b1;
            break;
         end
         n_stb++;
         n_stall += int'(stall_o);
         chk("bus addr", wb_addr_o, addr);
         chk("bus we",   {31'd0, wb_we_o}, {31'd0, we});
         chk("bus sel",  {28'd0, wb_sel_o}, {28'd0, sel});
         chk("bus wdat", wb_data_o, wdata);
         chk("bus cyc",  {31'd0, wb_cyc_o}, 32'd1);
         wb_ack_i  = (k == ack_wait);
         wb_data_i = (k == ack_wait) ? rdata : $urandom();
         @(negedge clk);
      end
      wb_ack_i = 1'b0;
      chk("txn done", {31'd0, done}, 32'd1);
      n_stall += int'(stall_o);
      chk("stall cyc",  n_stall, exp_stall);
      chk("stb cyc",    n_stb, exp_stb);
      chk("load data",  cpu_data_o, exp_data);
      chk("done cyc",   {31'd0, wb_cyc_o}, 32'd0);
      chk("done we",    {31'd0, wb_we_o}, 32'd0);
      chk("addr kept",  wb_addr_o, addr);
      chk("no bus err", {31'd0, bus_err_o}, 32'd0);
      // a new request while the pipeline is frozen must not start a cycle
      for (int h = 0; h < hold; h++) begin
         cpu_ce_i   = 1'b1;
         cpu_addr_i = $urandom();
         @(negedge clk);
         chk("hold state", {30'd0, dbg_state}, {30'd0, S_DONE});
         chk("hold stb",   {31'd0, wb_stb_o}, 32'd0);
         chk("hold stall", {31'd0, stall_o}, 32'd0);
         chk("hold data",  cpu_data_o, exp_data);
      end
      cpu_ce_i = 1'b0;
      stall_i  = 1'b0;
      @(negedge clk);
      chk("back idle", {30'd0, dbg_state}, {30'd0, S_IDLE});
   endtask

   // reference model at the transaction level
   task automatic model_txn(input logic we, input int ack_wait, input logic [31:0] rdata,
                            output int exp_stall, output int exp_stb);
      exp_stb   = ack_wait + 1;
      exp_stall = exp_stb + 1;
      if (!we) model_rd = rdata;
      exp_q.push_back(model_rd);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int es;
      int eb;
      logic        r_we;
      int          r_wait;
      int          r_hold;
      logic [31:0] r_rd;

      vecs[0] = '{1'b0, 32'h0000_0010, 4'hF, 32'h0, 0, 32'hDEAD_BEEF, 0, 2, 1, 32'hDEAD_BEEF};
      vecs[1] = '{1'b1, 32'h0000_0020, 4'b0011, 32'h0000_1234, 3, 32'hFFFF_FFFF, 0, 5, 4, 32'hDEAD_BEEF};
      vecs[2] = '{1'b0, 32'h0000_0024, 4'hF, 32'h0, 1, 32'hCAFE_F00D, 3, 3, 2, 32'hCAFE_F00D};
      vecs[3] = '{1'b0, 32'hFFFF_FFFC, 4'b1000, 32'h0, 2, 32'h0000_0001, 0, 4, 3, 32'h0000_0001};
      vecs[4] = '{1'b1, 32'h0000_0000, 4'hF, 32'hA5A5_A5A5, 0, 32'h7777_7777, 2, 2, 1, 32'h0000_0001};

      rst = 1'b0;
      cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_sel_i = '0; cpu_data_i = '0;
      stall_i = 1'b0; flush_i = 1'b0; wb_data_i = '0; wb_ack_i = 1'b0;
      #3;
      chk_all_zero("reset");
      cpu_ce_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // directed table
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(vecs[i].exp_data);
         if (!vecs[i].we) model_rd = vecs[i].rdata;
         run_txn(vecs[i].we, vecs[i].addr, vecs[i].sel, vecs[i].wdata, vecs[i].ack_wait,
                 vecs[i].rdata, vecs[i].hold, vecs[i].exp_stall, vecs[i].exp_stb);
      end

      // random transactions
      for (int i = 0; i < 20; i++) begin
         r_we   = 1'($urandom_range(0, 1));
         r_wait = $urandom_range(0, 5);
         r_hold = $urandom_range(0, 2);
         r_rd   = $urandom();
         model_txn(r_we, r_wait, r_rd, es, eb);
         run_txn(r_we, $urandom(), 4'($urandom_range(1, 15)), $urandom(), r_wait, r_rd, r_hold, es, eb);
      end

      // flush with a request in IDLE: nothing issued, no stall
      cpu_ce_i = 1'b1; flush_i = 1'b1;
      #1;
      chk("idle flush stall", {31'd0, stall_o}, 32'd0);
      @(negedge clk);
      chk("idle flush stb", {31'd0, wb_stb_o}, 32'd0);
      cpu_ce_i = 1'b0; flush_i = 1'b0;

      // flush in 2nd BUSY cycle, late ack one cycle after
      cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h40;
      @(negedge clk);
      cpu_ce_i = 1'b0;
      @(negedge clk);
      chk("flush busy stb", {31'd0, wb_stb_o}, 32'd1);
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      chk("flush cyc",   {31'd0, wb_cyc_o}, 32'd0);
      chk("flush stb",   {31'd0, wb_stb_o}, 32'd0);
      chk("flush stall", {31'd0, stall_o}, 32'd0);
      chk("flush state", {30'd0, dbg_state}, {30'd0, S_IDLE});
      wb_ack_i = 1'b1; wb_data_i = 32'h1111_1111;
      @(negedge clk);
      wb_ack_i = 1'b0;
      chk("late ack state", {30'd0, dbg_state}, {30'd0, S_IDLE});
      chk("late ack data",  cpu_data_o, model_rd);
      chk("late ack stb",   {31'd0, wb_stb_o}, 32'd0);

      // flush and ack in the same cycle: flush wins
      cpu_ce_i = 1'b1; cpu_addr_i = 32'h44;
      @(negedge clk);
      cpu_ce_i = 1'b0; flush_i = 1'b1; wb_ack_i = 1'b1; wb_data_i = 32'h2222_2222;
      @(negedge clk);
      flush_i = 1'b0; wb_ack_i = 1'b0;
      chk("flush+ack state", {30'd0, dbg_state}, {30'd0, S_IDLE});
      chk("flush+ack data",  cpu_data_o, model_rd);

      // flush in DONE while the pipeline is still frozen
      cpu_ce_i = 1'b1; cpu_addr_i = 32'h48; stall_i = 1'b1;
      @(negedge clk);
      cpu_ce_i = 1'b0; wb_ack_i = 1'b1; wb_data_i = 32'h5A5A_0000;
      @(negedge clk);
      wb_ack_i = 1'b0;
      model_rd = 32'h5A5A_0000;
      chk("done data",  cpu_data_o, model_rd);
      chk("done state", {30'd0, dbg_state}, {30'd0, S_DONE});
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0; stall_i = 1'b0;
      chk("done flush state", {30'd0, dbg_state}, {30'd0, S_IDLE});

      // reset pulled mid-BUSY
      cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h80; cpu_sel_i = 4'hF; cpu_data_i = 32'h99;
      @(negedge clk);
      cpu_ce_i = 1'b0;
      chk("pre-rst stb", {31'd0, wb_stb_o}, 32'd1);
      #2 rst = 1'b0;
      #1;
      chk_all_zero("mid rst");
      chk("mid rst state", {30'd0, dbg_state}, {30'd0, S_IDLE});
      @(negedge clk);
      rst = 1'b1;
      model_rd = '0;
      @(negedge clk);
      model_txn(1'b0, 1, 32'h0BAD_F00D, es, eb);
      run_txn(1'b0, 32'h84, 4'hF, 32'h0, 1, 32'h0BAD_F00D, 0, es, eb);

`ifdef BUS_TIMEOUT_EN
      begin
         int  n_stb;
         bit  ended;
         cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'hC0;
         @(negedge clk);
         cpu_ce_i = 1'b0;
         n_stb = 0;
         ended = 1'b0;
         for (int k = 0; k < 40; k++) begin
            if (!wb_stb_o) begin
               ended = 1'b1;
               break;
            end
            n_stb++;
            chk("to no err yet", {31'd0, bus_err_o}, 32'd0);
            @(negedge clk);
         end
         chk("to ended",    {31'd0, ended}, 32'd1);
         chk("to stb cyc",  n_stb, 4);
         chk("to err",      {31'd0, bus_err_o}, 32'd1);
         chk("to data",     cpu_data_o, 32'd0);
         chk("to stall",    {31'd0, stall_o}, 32'd0);
         @(negedge clk);
         chk("to err pulse", {31'd0, bus_err_o}, 32'd0);
         chk("to idle", {30'd0, dbg_state}, {30'd0, S_IDLE});
         model_rd = '0;
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // overall time bound
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

endmodule
